// File: rtl/key_event_ctrl_pkg.sv
// Shared definitions for the key event controller: event type codes,
// per-key FSM state encoding and the key-index width helper.
package key_pkg;

  // Event codes as presented on evt_type; EVT_NONE never leaves the block while valid.
  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_SHORT  = 2'b01,
    EVT_LONG   = 2'b10,
    EVT_REPEAT = 2'b11
  } evt_type_e;

  // Per-key timing FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_REPEAT  = 2'b10
  } key_fsm_e;

  // Width of a key index; a single key still needs one bit.
  function automatic int key_idx_width(input int n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Event output handshake: producer drives valid/key/type, consumer drives ready.
interface key_event_ctrl_if #(
  parameter int KW = 2
) ();
  logic          evt_valid;
  logic          evt_ready;
  logic [KW-1:0] evt_key;
  logic [1:0]    evt_type;

  modport master (output evt_valid, output evt_key, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_type, output evt_ready);
endinterface

// File: rtl/key_event_ctrl_timer.sv
// Per-key press timing: IDLE/PRESSED/REPEAT FSM with press and repeat
// counters, plus a one-deep pending event register drained by the arbiter.
module key_timer
  import key_pkg::*;
#(
  parameter int LONG_CNT_BITS   = 24,
  parameter int REPEAT_CNT_BITS = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pressed,     // normalised, registered key level
  input  logic       take,        // arbiter moves the pending event into the slot
  output logic       pend_valid,
  output logic [1:0] pend_type,
  output logic       drop         // event raised while pending is occupied
);

  key_fsm_e                   state_reg;
  logic [LONG_CNT_BITS-1:0]   press_cnt_reg;
  logic [REPEAT_CNT_BITS-1:0] rep_cnt_reg;
  logic                       pend_valid_reg;
  evt_type_e                  pend_type_reg;

  logic      raise;
  evt_type_e raise_type;

  // Event decode from the current state; release takes priority over the long threshold.
  always_comb begin
    raise      = 1'b0;
    raise_type = EVT_NONE;
    case (state_reg)
      ST_PRESSED: begin
        if (!pressed) begin
          raise      = 1'b1;
          raise_type = EVT_SHORT;
        end else if (&press_cnt_reg) begin
          raise      = 1'b1;
          raise_type = EVT_LONG;
        end
      end
      ST_REPEAT: begin
        if (pressed && (&rep_cnt_reg)) begin
          raise      = 1'b1;
          raise_type = EVT_REPEAT;
        end
      end
      default: ;
    endcase
  end

  // A slot being vacated on this edge can accept the new event, so only a
  // pending register that stays full causes a drop.
  assign drop       = raise & pend_valid_reg & ~take;
  assign pend_valid = pend_valid_reg;
  assign pend_type  = pend_type_reg;

  // Press timing FSM and its counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      press_cnt_reg <= '0;
      rep_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pressed) begin
            state_reg     <= ST_PRESSED;
            press_cnt_reg <= '0;
          end
        end
        ST_PRESSED: begin
          press_cnt_reg <= press_cnt_reg + LONG_CNT_BITS'(1);
          if (!pressed) begin
            state_reg <= ST_IDLE;
          end else if (&press_cnt_reg) begin
            state_reg   <= ST_REPEAT;
            rep_cnt_reg <= '0;
          end
        end
        ST_REPEAT: begin
          if (!pressed) begin
            state_reg <= ST_IDLE;
          end else begin
            rep_cnt_reg <= rep_cnt_reg + REPEAT_CNT_BITS'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // One-deep pending event register, loaded on the FSM transition edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_reg <= 1'b0;
      pend_type_reg  <= EVT_NONE;
    end else if (raise && (!pend_valid_reg || take)) begin
      pend_valid_reg <= 1'b1;
      pend_type_reg  <= raise_type;
    end else if (take) begin
      pend_valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: input capture, N_KEYS key timers, lowest-index
// priority arbiter feeding a single registered event slot, sticky overflow.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int LONG_CNT_BITS   = 24,
  parameter int REPEAT_CNT_BITS = 22,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  input  logic              ovf_clr,
  output logic [N_KEYS-1:0] key_state,
  output logic              ovf,
  key_event_ctrl_if.master  evt
);

  localparam int KW = key_idx_width(N_KEYS);

  logic [N_KEYS-1:0]      key_q_reg;     // pressed-normalised capture of key_in
  logic [N_KEYS-1:0]      pend_valid;
  logic [N_KEYS-1:0][1:0] pend_type;
  logic [N_KEYS-1:0]      drop;
  logic [N_KEYS-1:0]      take;
  logic [KW-1:0]          sel_idx;
  logic                   any_pend;
  logic                   slot_free;
  logic                   evt_valid_reg;
  logic [KW-1:0]          evt_key_reg;
  logic [1:0]             evt_type_reg;
  logic                   ovf_reg;

  // Single capture stage; stored already normalised so 1 always means pressed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q_reg <= '0;
    end else begin
      key_q_reg <= (ACTIVE_LOW != 0) ? ~key_in : key_in;
    end
  end

  assign key_state = key_q_reg;

  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      key_timer #(
        .LONG_CNT_BITS  (LONG_CNT_BITS),
        .REPEAT_CNT_BITS(REPEAT_CNT_BITS)
      ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .pressed   (key_q_reg[gi]),
        .take      (take[gi]),
        .pend_valid(pend_valid[gi]),
        .pend_type (pend_type[gi]),
        .drop      (drop[gi])
      );
    end
  endgenerate

  // Lowest-index pending key wins the slot.
  always_comb begin
    sel_idx  = '0;
    any_pend = 1'b0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend_valid[i]) begin
        sel_idx  = KW'(i);
        any_pend = 1'b1;
      end
    end
  end

  assign slot_free = ~evt_valid_reg | evt.evt_ready;
  assign take      = (slot_free && any_pend) ? (N_KEYS'(1) << sel_idx) : '0;

  // Output slot: refill whenever empty or being consumed, otherwise hold stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid_reg <= 1'b0;
      evt_key_reg   <= '0;
      evt_type_reg  <= EVT_NONE;
    end else if (slot_free) begin
      evt_valid_reg <= any_pend;
      if (any_pend) begin
        evt_key_reg  <= sel_idx;
        evt_type_reg <= pend_type[sel_idx];
      end
    end
  end

  // Sticky overflow; a drop on the same edge as the clear keeps it set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (|drop) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign evt.evt_valid = evt_valid_reg;
  assign evt.evt_key   = evt_key_reg;
  assign evt.evt_type  = evt_type_reg;
  assign ovf           = ovf_reg;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with short timing parameters
// (long press = 16 cycles, repeat period = 8 cycles, active-low keys).
module tb_key_event_ctrl;
  import key_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic       ovf_clr;
  logic [3:0] key_state;
  logic       ovf;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;

  key_event_ctrl_if #(.KW(2)) evt_if ();

  key_event_ctrl #(
    .N_KEYS         (4),
    .LONG_CNT_BITS  (4),
    .REPEAT_CNT_BITS(3),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .ovf_clr  (ovf_clr),
    .key_state(key_state),
    .ovf      (ovf),
    .evt      (evt_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One line per accepted event.
  always @(negedge clk) begin
    if (rst_n && evt_if.evt_valid && evt_if.evt_ready)
      $display("[TB] cycle %0d event key=%0d type=%0d", cyc, evt_if.evt_key, evt_if.evt_type);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input string tag, input bit v, input int k, input logic [1:0] t);
    check({tag, ".valid"}, 32'(evt_if.evt_valid), 32'(v));
    if (v) begin
      check({tag, ".key"}, 32'(evt_if.evt_key), 32'(k));
      check({tag, ".type"}, 32'(evt_if.evt_type), 32'(t));
    end
  endtask

  task automatic idle(input int n);
    key_in = 4'hF;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n            = 1'b0;
    key_in           = 4'hF;
    ovf_clr          = 1'b0;
    evt_if.evt_ready = 1'b1;
    tick(); tick(); tick();
    check("rst.valid", 32'(evt_if.evt_valid), 32'd0);
    check("rst.key_state", 32'(key_state), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Short press of key 0: five low cycles, event two edges after release capture.
    for (int i = 1; i <= 10; i++) begin
      if (i == 1) key_in[0] = 1'b0;
      if (i == 6) key_in[0] = 1'b1;
      tick();
      expect_evt($sformatf("short.c%0d", i), (i == 8), 0, EVT_SHORT);
    end
    idle(3);

    // Key 2 held: LONG then three REPEATs, nothing on release.
    for (int i = 1; i <= 52; i++) begin
      if (i == 1)  key_in[2] = 1'b0;
      if (i == 45) key_in[2] = 1'b1;
      tick();
      if (i == 3) check("long.key_state", 32'(key_state), 32'h4);
      if (i == 19)
        expect_evt($sformatf("long.c%0d", i), 1'b1, 2, EVT_LONG);
      else if (i == 27 || i == 35 || i == 43)
        expect_evt($sformatf("long.c%0d", i), 1'b1, 2, EVT_REPEAT);
      else
        expect_evt($sformatf("long.c%0d", i), 1'b0, 0, EVT_NONE);
    end
    check("long.key_state_rel", 32'(key_state), 32'h0);
    idle(3);

    // Release exactly at the long threshold: SHORT wins, no LONG.
    for (int i = 1; i <= 22; i++) begin
      if (i == 1)  key_in[0] = 1'b0;
      if (i == 17) key_in[0] = 1'b1;
      tick();
      expect_evt($sformatf("edge.c%0d", i), (i == 19), 0, EVT_SHORT);
    end
    idle(3);

    // Keys 1 and 3 released together: key 1 first, key 3 next cycle.
    for (int i = 1; i <= 10; i++) begin
      if (i == 1) key_in = 4'b0101;
      if (i == 5) key_in = 4'hF;
      tick();
      if (i == 7)      expect_evt($sformatf("pair.c%0d", i), 1'b1, 1, EVT_SHORT);
      else if (i == 8) expect_evt($sformatf("pair.c%0d", i), 1'b1, 3, EVT_SHORT);
      else             expect_evt($sformatf("pair.c%0d", i), 1'b0, 0, EVT_NONE);
    end
    idle(3);

    // Stalled consumer: slot holds first, pending holds second, third dropped.
    evt_if.evt_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 1 || i == 7 || i == 13)  key_in[0] = 1'b0;
      if (i == 4 || i == 10 || i == 16) key_in[0] = 1'b1;
      tick();
      expect_evt($sformatf("stall.c%0d", i), (i >= 6), 0, EVT_SHORT);
      check($sformatf("stall.ovf.c%0d", i), 32'(ovf), 32'(i >= 17));
    end
    evt_if.evt_ready = 1'b1;
    tick();
    expect_evt("drain.second", 1'b1, 0, EVT_SHORT);
    tick();
    expect_evt("drain.empty", 1'b0, 0, EVT_NONE);
    check("drain.ovf_sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);
    idle(3);

    // Reset mid-press of key 1, then a fresh short press.
    for (int i = 1; i <= 12; i++) begin
      if (i == 1)  key_in[1] = 1'b0;
      if (i == 12) rst_n = 1'b0;
      tick();
      if (i < 12) expect_evt($sformatf("rst_mid.c%0d", i), 1'b0, 0, EVT_NONE);
    end
    check("rst_mid.valid", 32'(evt_if.evt_valid), 32'd0);
    check("rst_mid.key", 32'(evt_if.evt_key), 32'd0);
    check("rst_mid.type", 32'(evt_if.evt_type), 32'd0);
    check("rst_mid.key_state", 32'(key_state), 32'd0);
    check("rst_mid.ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    for (int j = 1; j <= 22; j++) begin
      if (j == 16) key_in[1] = 1'b1;
      tick();
      if (j == 1) check("rst_post.key_state", 32'(key_state), 32'h2);
      expect_evt($sformatf("rst_post.c%0d", j), (j == 18), 1, EVT_SHORT);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
